// File: rtl/flag_ctrl.sv
// -----------------------------------------------------------------------------
// flag_ctrl
//
// Owns the shadow copy F of the processor status flags (bit0=Z, bit1=N,
// bit2=C) and the interrupt flag save/restore mechanism. Every change to F
// is presented one cycle later on flag_wdata/flag_we for the flag register.
//
// Build option:
//   FLAG_CTRL_NEST_EN defined   : DEPTH-entry save stack, nested interrupts.
//   FLAG_CTRL_NEST_EN undefined : one save slot; a push onto a full slot
//                                 overwrites it (and flags stack_ovf).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   alu_we/alu_flags/
//   alu_mask              masked flag update from the ALU
//   setc, clrc            force C to 1 / 0 (setc wins)
//   jmp_clr, jmp_sel      clear the flag consumed by a taken jump (3 = none)
//   int_req, rti_req      level requests, held until int_ack / rti_done
//   flag_wdata, flag_we   registered write port towards the flag register
//   int_ack, rti_done     one-cycle completion pulses
//   busy                  high while a save or restore is in progress
//   depth                 current save-stack occupancy
//   stack_ovf, stack_udf  sticky overflow / underflow indications
// -----------------------------------------------------------------------------
module flag_ctrl #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alu_we,
    input  logic [WIDTH-1:0]               alu_flags,
    input  logic [WIDTH-1:0]               alu_mask,
    input  logic                           setc,
    input  logic                           clrc,
    input  logic                           jmp_clr,
    input  logic [1:0]                     jmp_sel,
    input  logic                           int_req,
    input  logic                           rti_req,
    output logic [WIDTH-1:0]               flag_wdata,
    output logic                           flag_we,
    output logic                           int_ack,
    output logic                           rti_done,
    output logic                           busy,
    output logic [$clog2(DEPTH+1)-1:0]     depth,
    output logic                           stack_ovf,
    output logic                           stack_udf
);

    localparam int DW = $clog2(DEPTH + 1);

`ifdef FLAG_CTRL_NEST_EN
    localparam int SLOTS     = DEPTH;
    localparam bit OVERWRITE = 1'b0;
`else
    localparam int SLOTS     = 1;
    localparam bit OVERWRITE = 1'b1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   flags_q;
    logic [WIDTH-1:0]   flags_d;
    logic [DW-1:0]      depth_q;
    logic               flag_we_q;
    logic               int_ack_q;
    logic               rti_done_q;
    logic               busy_q;
    logic               ovf_q;
    logic               udf_q;
    logic [WIDTH-1:0]   stack_q [SLOTS];

    logic               upd_req;
    logic               upd_go;
    logic               int_go;
    logic               rti_go;
    logic               full;
    logic               push_wr;
    logic [DW-1:0]      wr_idx;
    logic [DW-1:0]      rd_idx;
    logic [WIDTH-1:0]   top_val;

    // A request whose acknowledge is on the output this cycle is the one just
    // served; the requester drops it after seeing the pulse, so it must not
    // start a second operation.
    assign int_go  = int_req && !int_ack_q;
    assign rti_go  = rti_req && !rti_done_q;
    assign upd_req = alu_we || jmp_clr || setc || clrc;
    assign upd_go  = (state_q == ST_IDLE) && !int_req && !rti_req && upd_req;

    assign full    = (depth_q == DW'(SLOTS));
    assign push_wr = (state_q == ST_SAVE) && (OVERWRITE || !full);
    assign wr_idx  = OVERWRITE ? '0 : depth_q;
    assign rd_idx  = depth_q - DW'(1);

    // Updates compose from the shadow F, so back-to-back requests never see a
    // stale flag register value.
    always_comb begin
        flags_d = flags_q;
        if (alu_we) begin
            flags_d = (flags_d & ~alu_mask) | (alu_flags & alu_mask);
        end
        if (jmp_clr) begin
            case (jmp_sel)
                2'd0:    flags_d[0] = 1'b0;
                2'd1:    flags_d[1] = 1'b0;
                2'd2:    flags_d[2] = 1'b0;
                default: ;
            endcase
        end
        if (setc) begin
            flags_d[2] = 1'b1;
        end else if (clrc) begin
            flags_d[2] = 1'b0;
        end
    end

    // Top-of-stack read; only used when depth_q is non-zero.
    always_comb begin
        top_val = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (rd_idx == DW'(i)) begin
                top_val = stack_q[i];
            end
        end
    end

    // Save stack storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push_wr) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (wr_idx == DW'(i)) begin
                    stack_q[i] <= flags_q;
                end
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            flags_q    <= '0;
            depth_q    <= '0;
            flag_we_q  <= 1'b0;
            int_ack_q  <= 1'b0;
            rti_done_q <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            flag_we_q  <= 1'b0;
            int_ack_q  <= 1'b0;
            rti_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (int_go) begin
                        state_q <= ST_SAVE;
                        busy_q  <= 1'b1;
                    end else if (rti_go) begin
                        state_q <= ST_RESTORE;
                        busy_q  <= 1'b1;
                    end else if (upd_go) begin
                        flags_q   <= flags_d;
                        flag_we_q <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    // Full stack: entry dropped (or slot overwritten) but the
                    // save still completes.
                    if (!full) begin
                        depth_q <= depth_q + DW'(1);
                    end else begin
                        ovf_q <= 1'b1;
                    end
                    flags_q   <= '0;
                    int_ack_q <= 1'b1;
                    flag_we_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                ST_RESTORE: begin
                    if (depth_q != '0) begin
                        flags_q <= top_val;
                        depth_q <= depth_q - DW'(1);
                    end else begin
                        flags_q <= '0;
                        udf_q   <= 1'b1;
                    end
                    rti_done_q <= 1'b1;
                    flag_we_q  <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign flag_wdata = flags_q;
    assign flag_we    = flag_we_q;
    assign int_ack    = int_ack_q;
    assign rti_done   = rti_done_q;
    assign busy       = busy_q;
    assign depth      = depth_q;
    assign stack_ovf  = ovf_q;
    assign stack_udf  = udf_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flag_ctrl
//
// Directed stimulus against flag_ctrl. A queue-based behavioural model
// predicts every output each cycle; a few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_flag_ctrl;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);

`ifdef FLAG_CTRL_NEST_EN
    localparam int CAP  = DEPTH;
    localparam bit NEST = 1'b1;
`else
    localparam int CAP  = 1;
    localparam bit NEST = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             alu_we;
    logic [WIDTH-1:0] alu_flags;
    logic [WIDTH-1:0] alu_mask;
    logic             setc;
    logic             clrc;
    logic             jmp_clr;
    logic [1:0]       jmp_sel;
    logic             int_req;
    logic             rti_req;
    logic [WIDTH-1:0] flag_wdata;
    logic             flag_we;
    logic             int_ack;
    logic             rti_done;
    logic             busy;
    logic [DW-1:0]    depth;
    logic             stack_ovf;
    logic             stack_udf;

    flag_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_we     (alu_we),
        .alu_flags  (alu_flags),
        .alu_mask   (alu_mask),
        .setc       (setc),
        .clrc       (clrc),
        .jmp_clr    (jmp_clr),
        .jmp_sel    (jmp_sel),
        .int_req    (int_req),
        .rti_req    (rti_req),
        .flag_wdata (flag_wdata),
        .flag_we    (flag_we),
        .int_ack    (int_ack),
        .rti_done   (rti_done),
        .busy       (busy),
        .depth      (depth),
        .stack_ovf  (stack_ovf),
        .stack_udf  (stack_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_f;
    int m_stack[$];
    bit m_ovf, m_udf, m_we, m_ack, m_done;
    int m_pend;          // 0 = nothing pending, 1 = save, 2 = restore
    bit m_prev_ack, m_prev_done;
    bit check_en = 1'b0;

    function automatic int model_upd();
        int f  = m_f;
        int mk = int'(alu_mask);
        if (alu_we) f = (f & ~mk) | (int'(alu_flags) & mk);
        if (jmp_clr && jmp_sel != 2'd3) f = f & ~(1 << jmp_sel);
        if (setc) f = f | 4;
        else if (clrc) f = f & ~4;
        return f & 7;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_f = 0;
            m_stack.delete();
            m_ovf = 0; m_udf = 0; m_we = 0; m_ack = 0; m_done = 0;
            m_pend = 0;
        end else begin
            m_prev_ack  = m_ack;
            m_prev_done = m_done;
            m_we = 0; m_ack = 0; m_done = 0;
            if (m_pend == 1) begin
                if (m_stack.size() < CAP) m_stack.push_back(m_f);
                else begin
                    m_ovf = 1;
                    if (!NEST) m_stack[0] = m_f;
                end
                m_f = 0; m_ack = 1; m_we = 1; m_pend = 0;
            end else if (m_pend == 2) begin
                if (m_stack.size() > 0) m_f = m_stack.pop_back();
                else begin
                    m_f = 0; m_udf = 1;
                end
                m_done = 1; m_we = 1; m_pend = 0;
            end else if (int_req && !m_prev_ack) begin
                m_pend = 1;
            end else if (rti_req && !m_prev_done) begin
                m_pend = 2;
            end else if (!int_req && !rti_req && (alu_we || jmp_clr || setc || clrc)) begin
                m_f  = model_upd();
                m_we = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_flag_wdata", int'(flag_wdata), m_f);
            chk("cyc_flag_we",    int'(flag_we),    int'(m_we));
            chk("cyc_int_ack",    int'(int_ack),    int'(m_ack));
            chk("cyc_rti_done",   int'(rti_done),   int'(m_done));
            chk("cyc_busy",       int'(busy),       int'(m_pend != 0));
            chk("cyc_depth",      int'(depth),      m_stack.size());
            chk("cyc_stack_ovf",  int'(stack_ovf),  int'(m_ovf));
            chk("cyc_stack_udf",  int'(stack_udf),  int'(m_udf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        alu_we = 0; alu_flags = '0; alu_mask = '0;
        setc = 0; clrc = 0; jmp_clr = 0; jmp_sel = 2'd0;
        int_req = 0; rti_req = 0;
    endtask

    task automatic upd(input bit we, input int fl, input int mk, input bit sc,
                       input bit cc, input bit jc, input int js);
        alu_we = we; alu_flags = WIDTH'(fl); alu_mask = WIDTH'(mk);
        setc = sc; clrc = cc; jmp_clr = jc; jmp_sel = 2'(js);
        tick();
        $display("txn upd: we=%0d fl=%0d mk=%0d setc=%0d clrc=%0d jclr=%0d jsel=%0d -> flag_we=%0d wdata=%0d",
                 we, fl, mk, sc, cc, jc, js, flag_we, flag_wdata);
        clear_in();
    endtask

    task automatic do_int(output int busy_cycles);
        int k;
        busy_cycles = 0;
        int_req = 1;
        for (k = 0; k < 10; k++) begin
            tick();
            if (busy) busy_cycles++;
            if (int_ack) break;
        end
        if (k == 10) chk("int_ack_timeout", int'(int_ack), 1);
        $display("txn int: ack=%0d depth=%0d wdata=%0d busy_cycles=%0d ovf=%0d",
                 int_ack, depth, flag_wdata, busy_cycles, stack_ovf);
        int_req = 0;
    endtask

    task automatic do_rti(output int busy_cycles);
        int k;
        busy_cycles = 0;
        rti_req = 1;
        for (k = 0; k < 10; k++) begin
            tick();
            if (busy) busy_cycles++;
            if (rti_done) break;
        end
        if (k == 10) chk("rti_done_timeout", int'(rti_done), 1);
        $display("txn rti: done=%0d depth=%0d wdata=%0d busy_cycles=%0d udf=%0d",
                 rti_done, depth, flag_wdata, busy_cycles, stack_udf);
        rti_req = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
        $display("txn reset");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int bc;
        reset = 1;
        clear_in();
        tick();
        check_en = 1;
        tick();
        chk("rst_flag_wdata", int'(flag_wdata), 0);
        chk("rst_flag_we",    int'(flag_we),    0);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_depth",      int'(depth),      0);
        chk("rst_ovf_udf",    int'({stack_ovf, stack_udf, int_ack, rti_done}), 0);
        reset = 0;

        // Masked ALU update.
        upd(1, 3'b011, 3'b011, 0, 0, 0, 0);
        chk("alu_upd_we",    int'(flag_we),    1);
        chk("alu_upd_wdata", int'(flag_wdata), 3);

        // setc beats clrc, jump clears Z.
        upd(1, 3'b001, 3'b111, 0, 0, 0, 0);
        upd(0, 0, 0, 1, 1, 1, 0);
        chk("setc_wins_wdata", int'(flag_wdata), 4);
        chk("setc_wins_we",    int'(flag_we),    1);

        // Back-to-back updates composed from F.
        alu_we = 1; alu_flags = 3'b001; alu_mask = 3'b011;
        tick();
        clear_in(); jmp_clr = 1; jmp_sel = 2'd2;
        tick();
        clear_in(); alu_we = 1; alu_flags = 3'b010; alu_mask = 3'b010;
        tick();
        chk("b2b_wdata", int'(flag_wdata), 3);
        clear_in(); jmp_clr = 1; jmp_sel = 2'd3;
        tick();
        chk("jsel_none_we",    int'(flag_we),    1);
        chk("jsel_none_wdata", int'(flag_wdata), 3);
        clear_in();
        tick();
        chk("idle_no_we", int'(flag_we), 0);

        // Save / restore round trip.
        upd(1, 3'b101, 3'b111, 0, 0, 0, 0);
        do_int(bc);
        chk("save_busy_cycles", bc, 1);
        chk("save_wdata",       int'(flag_wdata), 0);
        chk("save_depth",       int'(depth),      1);
        do_rti(bc);
        chk("restore_done",  int'(rti_done),   1);
        chk("restore_wdata", int'(flag_wdata), 5);
        chk("restore_depth", int'(depth),      0);
        tick();

        // Update requested alongside and during an interrupt is ignored.
        alu_we = 1; alu_flags = 3'b111; alu_mask = 3'b111;
        do_int(bc);
        clear_in();
        tick();
        chk("upd_in_int_ignored", int'(flag_wdata), 0);
        do_rti(bc);
        chk("upd_in_int_restore", int'(flag_wdata), 5);
        tick();

        // Nesting beyond capacity, then unwinding past empty.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            upd(1, i + 1, 3'b111, 0, 0, 0, 0);
            do_int(bc);
        end
        chk("nest_ovf",   int'(stack_ovf), 1);
        chk("nest_depth", int'(depth),     NEST ? 4 : 1);
        for (int i = 0; i < 5; i++) begin
            do_rti(bc);
            if (i == 0) chk("first_pop_wdata", int'(flag_wdata), NEST ? 4 : 5);
        end
        chk("unwind_udf",   int'(stack_udf),  1);
        chk("unwind_wdata", int'(flag_wdata), 0);
        chk("unwind_depth", int'(depth),      0);
        tick();

        // Reset during SAVE aborts it.
        do_reset();
        upd(1, 3'b110, 3'b111, 0, 0, 0, 0);
        int_req = 1;
        tick();
        chk("abort_busy_before", int'(busy), 1);
        reset = 1; int_req = 0;
        tick();
        chk("abort_no_ack", int'(int_ack),    0);
        chk("abort_depth",  int'(depth),      0);
        chk("abort_wdata",  int'(flag_wdata), 0);
        chk("abort_busy",   int'(busy),       0);
        reset = 0;
        $display("txn reset during save");
        tick();
        chk("abort_no_ack_late", int'(int_ack), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
